// File: rtl/micro_sequencer.sv
// micro_sequencer: next-address controller for a microprogrammed control unit.
// Chooses the next control-memory address from the sequencing field of the
// current micro-word, the IR opcode and the ALU flag. It also keeps a small
// return-address stack for micro-subroutines.
module micro_sequencer #(
  parameter int unsigned          ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]    FETCH_ADDR  = 8'h00,
  parameter int unsigned          STACK_DEPTH = 4,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       opcode,
  input  logic                             flag,
  input  logic [2:0]                       seq_op,
  input  logic [ADDR_W-1:0]                seq_target,
  input  logic                             mem_busy,
  output logic [ADDR_W-1:0]                micro_addr,
  output logic                             stalled,
  output logic                             halted,
  output logic                             stack_err,
  output logic [$clog2(STACK_DEPTH):0]     stack_level,
  output logic [CNT_W-1:0]                 uinstr_count
);

  localparam int unsigned SL_W  = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam logic [SL_W-1:0] FULL_LEVEL = SL_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JUMP = 3'd1,
    OP_MAP  = 3'd2,
    OP_BRT  = 3'd3,
    OP_BRF  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_HALT = 3'd7
  } seq_op_e;

  logic [ADDR_W-1:0] micro_addr_q, micro_addr_d;
  logic              halted_q, halted_d;
  logic              stack_err_q, stack_err_d;
  logic [SL_W-1:0]   stack_level_q, stack_level_d;
  logic [CNT_W-1:0]  uinstr_count_q, uinstr_count_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  seq_op_e           op;
  logic              step;
  logic [ADDR_W-1:0] inc;
  logic [PTR_W-1:0]  push_idx;
  logic [PTR_W-1:0]  pop_idx;

  // Next-address selection, stack push/pop and retired-instruction counting.
  always_comb begin
    micro_addr_d   = micro_addr_q;
    halted_d       = halted_q;
    stack_err_d    = stack_err_q;
    stack_level_d  = stack_level_q;
    uinstr_count_d = uinstr_count_q;
    stack_d        = stack_q;
    op             = seq_op_e'(seq_op);
    step           = ~mem_busy & ~halted_q;
    inc            = micro_addr_q + 1'b1;
    // The level counts occupancy, so it is the push slot and level-1 is the top.
    push_idx       = stack_level_q[PTR_W-1:0];
    pop_idx        = PTR_W'(stack_level_q - 1'b1);

    if (step) begin
      if (uinstr_count_q != '1) begin
        uinstr_count_d = uinstr_count_q + 1'b1;
      end
      unique case (op)
        OP_NEXT: micro_addr_d = inc;
        OP_JUMP: micro_addr_d = seq_target;
        OP_MAP:  micro_addr_d = ADDR_W'(opcode);
        OP_BRT:  micro_addr_d = flag ? seq_target : inc;
        OP_BRF:  micro_addr_d = flag ? inc : seq_target;
        OP_CALL: begin
          micro_addr_d = seq_target;
          if (stack_level_q == FULL_LEVEL) begin
            stack_err_d = 1'b1;
          end else begin
            stack_d[push_idx] = inc;
            stack_level_d     = stack_level_q + 1'b1;
          end
        end
        OP_RET: begin
          if (stack_level_q == '0) begin
            micro_addr_d = FETCH_ADDR;
            stack_err_d  = 1'b1;
          end else begin
            micro_addr_d  = stack_q[pop_idx];
            stack_level_d = stack_level_q - 1'b1;
          end
        end
        OP_HALT: halted_d = 1'b1;
        default: micro_addr_d = micro_addr_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      micro_addr_q   <= FETCH_ADDR;
      halted_q       <= 1'b0;
      stack_err_q    <= 1'b0;
      stack_level_q  <= '0;
      uinstr_count_q <= '0;
    end else begin
      micro_addr_q   <= micro_addr_d;
      halted_q       <= halted_d;
      stack_err_q    <= stack_err_d;
      stack_level_q  <= stack_level_d;
      uinstr_count_q <= uinstr_count_d;
    end
  end

  // Return-address storage; contents are meaningless after reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign micro_addr   = micro_addr_q;
  assign stalled      = mem_busy & ~halted_q;
  assign halted       = halted_q;
  assign stack_err    = stack_err_q;
  assign stack_level  = stack_level_q;
  assign uinstr_count = uinstr_count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer.
// A 5-bit counter is used so that saturation can be reached in a short run.
module tb_micro_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] opcode;
  logic       flag;
  logic [2:0] seq_op;
  logic [7:0] seq_target;
  logic       mem_busy;
  logic [7:0] micro_addr;
  logic       stalled;
  logic       halted;
  logic       stack_err;
  logic [2:0] stack_level;
  logic [4:0] uinstr_count;

  int checks = 0;
  int errors = 0;

  micro_sequencer #(
    .ADDR_W(8),
    .FETCH_ADDR(8'h00),
    .STACK_DEPTH(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .opcode(opcode),
    .flag(flag),
    .seq_op(seq_op),
    .seq_target(seq_target),
    .mem_busy(mem_busy),
    .micro_addr(micro_addr),
    .stalled(stalled),
    .halted(halted),
    .stack_err(stack_err),
    .stack_level(stack_level),
    .uinstr_count(uinstr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_busy = 1'b0; seq_op = 3'd0; flag = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 8'h00; flag = 1'b0; seq_op = 3'd0; seq_target = 8'h00; mem_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (micro_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", micro_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", stack_err); end
    checks++; if (stack_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", stack_level); end
    checks++; if (uinstr_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", uinstr_count); end
    checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled: got %b want 0", stalled); end
    seq_op = 3'd0;
    tick();
    checks++; if (micro_addr !== 8'h01) begin errors++; $display("FAIL next1: got %h want 01", micro_addr); end
    tick();
    checks++; if (micro_addr !== 8'h02) begin errors++; $display("FAIL next2: got %h want 02", micro_addr); end
    tick();
    checks++; if (micro_addr !== 8'h03) begin errors++; $display("FAIL next3: got %h want 03", micro_addr); end
    checks++; if (uinstr_count !== 5'd3) begin errors++; $display("FAIL next_count: got %0d want 3", uinstr_count); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL next_halted: got %b want 0", halted); end
  endtask

  task automatic test_map_branch();
    do_reset();
    seq_op = 3'd0;
    tick(); tick();
    checks++; if (micro_addr !== 8'h02) begin errors++; $display("FAIL pre_map: got %h want 02", micro_addr); end
    seq_op = 3'd2; opcode = 8'h4C;
    tick();
    checks++; if (micro_addr !== 8'h4C) begin errors++; $display("FAIL map: got %h want 4c", micro_addr); end
    seq_op = 3'd3; seq_target = 8'h90; flag = 1'b1;
    tick();
    checks++; if (micro_addr !== 8'h90) begin errors++; $display("FAIL brt_taken: got %h want 90", micro_addr); end
    seq_op = 3'd4; seq_target = 8'h20; flag = 1'b1;
    tick();
    checks++; if (micro_addr !== 8'h91) begin errors++; $display("FAIL brf_not_taken: got %h want 91", micro_addr); end
    seq_op = 3'd3; seq_target = 8'h55; flag = 1'b0;
    tick();
    checks++; if (micro_addr !== 8'h92) begin errors++; $display("FAIL brt_not_taken: got %h want 92", micro_addr); end
    seq_op = 3'd4; seq_target = 8'h20; flag = 1'b0;
    tick();
    checks++; if (micro_addr !== 8'h20) begin errors++; $display("FAIL brf_taken: got %h want 20", micro_addr); end
    checks++; if (uinstr_count !== 5'd7) begin errors++; $display("FAIL branch_count: got %0d want 7", uinstr_count); end
  endtask

  task automatic test_stall();
    // Continues from address 20 with count 7.
    seq_op = 3'd1; seq_target = 8'h33; mem_busy = 1'b1;
    #1;
    checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_comb: got %b want 1", stalled); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (micro_addr !== 8'h20) begin errors++; $display("FAIL stall_addr%0d: got %h want 20", i, micro_addr); end
      checks++; if (uinstr_count !== 5'd7) begin errors++; $display("FAIL stall_count%0d: got %0d want 7", i, uinstr_count); end
      checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_flag%0d: got %b want 1", i, stalled); end
    end
    mem_busy = 1'b0;
    #1;
    checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", stalled); end
    tick();
    checks++; if (micro_addr !== 8'h33) begin errors++; $display("FAIL stall_jump: got %h want 33", micro_addr); end
    checks++; if (uinstr_count !== 5'd8) begin errors++; $display("FAIL stall_count_after: got %0d want 8", uinstr_count); end
  endtask

  task automatic test_call_ret();
    do_reset();
    seq_op = 3'd1; seq_target = 8'h10;
    tick();
    checks++; if (micro_addr !== 8'h10) begin errors++; $display("FAIL cr_jump: got %h want 10", micro_addr); end
    seq_op = 3'd5; seq_target = 8'h40;
    tick();
    checks++; if (micro_addr !== 8'h40 || stack_level !== 3'd1) begin errors++; $display("FAIL call1: got %h/%0d want 40/1", micro_addr, stack_level); end
    seq_op = 3'd5; seq_target = 8'h60;
    tick();
    checks++; if (micro_addr !== 8'h60 || stack_level !== 3'd2) begin errors++; $display("FAIL call2: got %h/%0d want 60/2", micro_addr, stack_level); end
    seq_op = 3'd6;
    tick();
    checks++; if (micro_addr !== 8'h41 || stack_level !== 3'd1) begin errors++; $display("FAIL ret1: got %h/%0d want 41/1", micro_addr, stack_level); end
    tick();
    checks++; if (micro_addr !== 8'h11 || stack_level !== 3'd0) begin errors++; $display("FAIL ret2: got %h/%0d want 11/0", micro_addr, stack_level); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL cr_err: got %b want 0", stack_err); end
  endtask

  task automatic test_overflow();
    logic [7:0] tgt;
    logic [2:0] lvl;
    do_reset();
    // Return addresses pushed: 01, 11, 21, 31; the fifth call cannot push.
    for (int i = 0; i < 5; i++) begin
      tgt = 8'((i + 1) * 16);
      lvl = (i < 4) ? 3'(i + 1) : 3'd4;
      seq_op = 3'd5; seq_target = tgt;
      tick();
      checks++; if (micro_addr !== tgt || stack_level !== lvl || stack_err !== (i == 4)) begin
        errors++; $display("FAIL ovf_call%0d: got %h/%0d/%b want %h/%0d/%b", i, micro_addr, stack_level, stack_err, tgt, lvl, (i == 4));
      end
    end
    seq_op = 3'd6;
    tick();
    checks++; if (micro_addr !== 8'h31 || stack_level !== 3'd3 || stack_err !== 1'b1) begin
      errors++; $display("FAIL ovf_ret: got %h/%0d/%b want 31/3/1", micro_addr, stack_level, stack_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (micro_addr !== 8'h00 || stack_level !== 3'd0 || stack_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_call: got %h/%0d/%b want 00/0/0", micro_addr, stack_level, stack_err);
    end
    seq_op = 3'd1; seq_target = 8'h77;
    tick();
    seq_op = 3'd6;
    tick();
    checks++; if (micro_addr !== 8'h00 || stack_level !== 3'd0 || stack_err !== 1'b1) begin
      errors++; $display("FAIL underflow: got %h/%0d/%b want 00/0/1", micro_addr, stack_level, stack_err);
    end
  endtask

  task automatic test_wrap_halt();
    do_reset();
    seq_op = 3'd1; seq_target = 8'hFF;
    tick();
    seq_op = 3'd0;
    tick();
    checks++; if (micro_addr !== 8'h00) begin errors++; $display("FAIL wrap: got %h want 00", micro_addr); end
    seq_op = 3'd1; seq_target = 8'h05;
    tick();
    seq_op = 3'd7;
    tick();
    checks++; if (micro_addr !== 8'h05 || halted !== 1'b1 || uinstr_count !== 5'd4) begin
      errors++; $display("FAIL halt: got %h/%b/%0d want 05/1/4", micro_addr, halted, uinstr_count);
    end
    seq_op = 3'd0; mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (micro_addr !== 8'h05 || uinstr_count !== 5'd4 || stalled !== 1'b0 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_hold%0d: got %h/%0d/%b/%b want 05/4/0/1", i, micro_addr, uinstr_count, stalled, halted);
      end
    end
    mem_busy = 1'b0;
    tick();
    checks++; if (micro_addr !== 8'h05 || uinstr_count !== 5'd4) begin
      errors++; $display("FAIL halt_free: got %h/%0d want 05/4", micro_addr, uinstr_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (micro_addr !== 8'h00 || halted !== 1'b0 || uinstr_count !== 5'd0) begin
      errors++; $display("FAIL rst_mid_halt: got %h/%b/%0d want 00/0/0", micro_addr, halted, uinstr_count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    seq_op = 3'd0;
    repeat (40) tick();
    checks++; if (uinstr_count !== 5'd31 || micro_addr !== 8'h28) begin
      errors++; $display("FAIL saturate: got %0d/%h want 31/28", uinstr_count, micro_addr);
    end
    mem_busy = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (micro_addr !== 8'h00 || uinstr_count !== 5'd0 || stalled !== 1'b1) begin
      errors++; $display("FAIL rst_mid_stall: got %h/%0d/%b want 00/0/1", micro_addr, uinstr_count, stalled);
    end
    tick();
    checks++; if (micro_addr !== 8'h00) begin errors++; $display("FAIL stall_after_rst: got %h want 00", micro_addr); end
    mem_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_map_branch();
    test_stall();
    test_call_ret();
    test_overflow();
    test_wrap_halt();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
